// File: rtl/memstream_port_sequencer.sv
// memstream_port_sequencer
// Owns one port of a dual-port block-RAM weight store. Streams the region
// START_ADDR..START_ADDR+DEPTH-1 cyclically as AXI-Stream words and lets
// single-word config writes take the port whenever they are requested.
//
// Handshake: a word moves on m_axis when m_axis_tvalid && m_axis_tready are
// both high at a rising aclk edge; once tvalid is high, tdata and tlast hold
// until that edge. cfg_we is a request that is always granted in the same
// cycle (cfg_ack mirrors it), so a write never waits.
module memstream_port_sequencer #(
  parameter int AWIDTH     = 10,
  parameter int DWIDTH     = 18,
  parameter int START_ADDR = 0,
  parameter int DEPTH      = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [AWIDTH-1:0] cfg_addr,
  input  logic [DWIDTH-1:0] cfg_wdata,
  output logic              cfg_ack,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_wdata,
  input  logic [DWIDTH-1:0] ram_rdq,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  // FIFO index width, and a counter width wide enough for count + 2 in flight.
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 3);

  localparam logic [AWIDTH-1:0] FIRST_ADDR = AWIDTH'(START_ADDR);
  localparam logic [AWIDTH-1:0] LAST_ADDR  = AWIDTH'(START_ADDR + DEPTH - 1);
  localparam logic [CW-1:0]     FIFO_CAP   = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]     LAST_IDX   = PW'(FIFO_DEPTH - 1);

  // Read-side state.
  logic [AWIDTH-1:0] rd_ptr;
  logic [1:0]        v;        // v[0]: issued last cycle, v[1]: data on ram_rdq now
  logic [1:0]        lp;       // last-of-period flag travelling alongside v

  // Output FIFO; each entry is {last, data}.
  logic [DWIDTH:0]   fifo_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0]     wr_idx;
  logic [PW-1:0]     rd_idx;
  logic [CW-1:0]     fifo_count;

  logic              cfg_grant;
  logic [CW-1:0]     credit;
  logic              issue;
  logic              rd_at_last;
  logic              push;
  logic              pop;
  logic [DWIDTH:0]   head;

  // Writes are held off while reset is active so the port stays quiet.
  assign cfg_grant  = cfg_we & aresetn;

  // Credit counts buffered words plus reads still inside the RAM pipeline.
  // A pop in the current cycle is deliberately not credited back.
  assign credit     = fifo_count + CW'(v[0]) + CW'(v[1]);
  assign issue      = ~cfg_grant & enable & (credit < FIFO_CAP);
  assign rd_at_last = (rd_ptr == LAST_ADDR);

  assign push       = v[1];
  assign pop        = m_axis_tvalid & m_axis_tready;

  // First-word-fall-through head; data and last are forced low while empty.
  assign head          = fifo_mem[rd_idx];
  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[DWIDTH-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & head[DWIDTH];

  // Port arbitration: a config write owns the port, otherwise it points at rd_ptr.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = rd_ptr;
    ram_wdata = '0;
    cfg_ack   = 1'b0;
    if (cfg_grant) begin
      ram_we    = 1'b1;
      ram_addr  = cfg_addr;
      ram_wdata = cfg_wdata;
      cfg_ack   = 1'b1;
    end
  end

  // Read pointer walks the region and wraps after the last word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr <= FIRST_ADDR;
    end else if (issue) begin
      rd_ptr <= rd_at_last ? FIRST_ADDR : rd_ptr + AWIDTH'(1);
    end
  end

  // Two-stage pipe matching the RAM read latency, with the last flag in step.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v  <= 2'b00;
      lp <= 2'b00;
    end else begin
      v  <= {v[0], issue};
      lp <= {lp[0], issue & rd_at_last};
    end
  end

  // FIFO storage: capture the returning RAM word together with its last flag.
  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_mem[wr_idx] <= {lp[1], ram_rdq};
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count alone.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + PW'(1);
      end
      if (pop) begin
        rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_memstream_port_sequencer.sv
// Bench for memstream_port_sequencer: instance A (START_ADDR=2, DEPTH=4) is
// driven from a per-cycle vector table and hand sequences; instance B
// (AWIDTH=4, DEPTH=16) streams 200 words under random backpressure.
module tb_memstream_port_sequencer;

  localparam int DW   = 18;
  localparam int AW_A = 10;
  localparam int AW_B = 4;
  localparam int FD   = 4;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  // ---------------- instance A signals ----------------
  logic            a_enable, a_cfg_we, a_cfg_ack, a_ram_we, a_tvalid, a_tready, a_tlast;
  logic [AW_A-1:0] a_cfg_addr, a_ram_addr;
  logic [DW-1:0]   a_cfg_wdata, a_ram_wdata, a_rdq, a_r1, a_tdata;

  // ---------------- instance B signals ----------------
  logic            b_enable, b_cfg_we, b_cfg_ack, b_ram_we, b_tvalid, b_tready, b_tlast;
  logic [AW_B-1:0] b_cfg_addr, b_ram_addr;
  logic [DW-1:0]   b_cfg_wdata, b_ram_wdata, b_rdq, b_r1, b_tdata;

  memstream_port_sequencer #(
    .AWIDTH(AW_A), .DWIDTH(DW), .START_ADDR(2), .DEPTH(4), .FIFO_DEPTH(FD)
  ) dut_a (
    .aclk(aclk), .aresetn(aresetn), .enable(a_enable),
    .cfg_we(a_cfg_we), .cfg_addr(a_cfg_addr), .cfg_wdata(a_cfg_wdata), .cfg_ack(a_cfg_ack),
    .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rdq(a_rdq),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
    .m_axis_tlast(a_tlast)
  );

  memstream_port_sequencer #(
    .AWIDTH(AW_B), .DWIDTH(DW), .START_ADDR(0), .DEPTH(16), .FIFO_DEPTH(FD)
  ) dut_b (
    .aclk(aclk), .aresetn(aresetn), .enable(b_enable),
    .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_wdata(b_cfg_wdata), .cfg_ack(b_cfg_ack),
    .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdq(b_rdq),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
    .m_axis_tlast(b_tlast)
  );

  // ---------------- RAM models (read-first, 2-cycle registered read) ----------------
  function automatic logic [DW-1:0] def_a(input logic [AW_A-1:0] a);
    return 18'h100 + 18'(a);
  endfunction

  function automatic logic [DW-1:0] def_b(input logic [AW_B-1:0] a);
    return 18'h2000 + 18'(a) * 18'd7;
  endfunction

  bit            wflag_a [0:1023];
  logic [DW-1:0] wmem_a  [0:1023];
  bit            wflag_b [0:15];
  logic [DW-1:0] wmem_b  [0:15];

  always @(posedge aclk) begin
    if (a_ram_we) begin
      wflag_a[a_ram_addr] <= 1'b1;
      wmem_a[a_ram_addr]  <= a_ram_wdata;
    end
    a_r1  <= wflag_a[a_ram_addr] ? wmem_a[a_ram_addr] : def_a(a_ram_addr);
    a_rdq <= a_r1;
  end

  always @(posedge aclk) begin
    if (b_ram_we) begin
      wflag_b[b_ram_addr] <= 1'b1;
      wmem_b[b_ram_addr]  <= b_ram_wdata;
    end
    b_r1  <= wflag_b[b_ram_addr] ? wmem_b[b_ram_addr] : def_b(b_ram_addr);
    b_rdq <= b_r1;
  end

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [DW:0] exp_qa[$];
  logic [DW:0] exp_qb[$];
  logic        sb_a_on = 1'b0;
  logic        sb_b_on = 1'b0;
  logic        cfg4_done = 1'b0;
  int          a_words = 0;
  int          b_words = 0;
  int          b_lasts = 0;

  // Expected A stream: addresses 2..5 cyclic; address 4 holds 0x3AA once written.
  task automatic fill_a(input int n);
    logic [AW_A-1:0] a;
    logic [DW-1:0]   d;
    exp_qa.delete();
    for (int i = 0; i < n; i++) begin
      a = AW_A'(2 + (i % 4));
      d = (cfg4_done && a == AW_A'(4)) ? 18'h3AA : def_a(a);
      exp_qa.push_back({a == AW_A'(5), d});
    end
  endtask

  task automatic fill_b(input int n);
    logic [AW_B-1:0] a;
    exp_qb.delete();
    for (int i = 0; i < n; i++) begin
      a = AW_B'(i % 16);
      exp_qb.push_back({a == AW_B'(15), def_b(a)});
    end
  endtask

  always @(negedge aclk) begin : mon_a
    logic [DW:0] e;
    if (sb_a_on && aresetn && a_tvalid && a_tready) begin
      if (exp_qa.size() == 0) begin
        check("sb_a_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_qa.pop_front();
        check("sb_a_data", 32'(a_tdata), 32'(e[DW-1:0]));
        check("sb_a_last", 32'(a_tlast), 32'(e[DW]));
      end
      a_words++;
    end
  end

  always @(negedge aclk) begin : mon_b
    logic [DW:0] e;
    if (sb_b_on && aresetn && b_tvalid && b_tready) begin
      if (exp_qb.size() == 0) begin
        check("sb_b_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_qb.pop_front();
        check("sb_b_data", 32'(b_tdata), 32'(e[DW-1:0]));
        check("sb_b_last", 32'(b_tlast), 32'(e[DW]));
      end
      b_words++;
      if (b_tlast) b_lasts++;
    end
  end

  // A stalled word must stay valid and unchanged until it is accepted.
  logic        a_stall = 1'b0, b_stall = 1'b0;
  logic [DW:0] a_held, b_held;
  always @(negedge aclk) begin
    if (aresetn && a_stall) begin
      check("axi_hold_valid_a", 32'(a_tvalid), 32'd1);
      check("axi_hold_word_a", 32'({a_tlast, a_tdata}), 32'(a_held));
    end
    if (aresetn && b_stall) begin
      check("axi_hold_valid_b", 32'(b_tvalid), 32'd1);
      check("axi_hold_word_b", 32'({b_tlast, b_tdata}), 32'(b_held));
    end
    a_stall <= aresetn && a_tvalid && !a_tready;
    b_stall <= aresetn && b_tvalid && !b_tready;
    a_held  <= {a_tlast, a_tdata};
    b_held  <= {b_tlast, b_tdata};
  end

  // Counts edges at which a push would land in a full FIFO with no pop.
  int ovf = 0;
  always @(negedge aclk) begin
    if (aresetn) begin
      ovf <= ovf
           + int'(dut_a.push && !dut_a.pop && int'(dut_a.fifo_count) == FD)
           + int'(dut_b.push && !dut_b.pop && int'(dut_b.fifo_count) == FD);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic            en;
    logic            we;
    logic [AW_A-1:0] waddr;
    logic [DW-1:0]   wdata;
    logic            rdy;
    logic            x_we;
    logic [AW_A-1:0] x_addr;
    logic            x_ack;
    logic            x_valid;
    logic [DW-1:0]   x_data;
    logic            x_last;
  } vec_t;

  function automatic vec_t mk(input logic [AW_A-1:0] addr, input logic we,
                              input logic valid, input logic [DW-1:0] data,
                              input logic last);
    vec_t t;
    t.en = 1'b1; t.we = we; t.waddr = AW_A'(4); t.wdata = 18'h3AA; t.rdy = 1'b1;
    t.x_we = we; t.x_addr = addr; t.x_ack = we;
    t.x_valid = valid; t.x_data = data; t.x_last = last;
    return t;
  endfunction

  vec_t vecs [16];

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    a_enable = 1'b0; a_tready = 1'b0; a_cfg_we = 1'b0;
    b_enable = 1'b0; b_tready = 1'b0; b_cfg_we = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  // Hard stop if the run ever wedges.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int win;
    a_enable = 0; a_cfg_we = 0; a_cfg_addr = '0; a_cfg_wdata = '0; a_tready = 0;
    b_enable = 0; b_cfg_we = 0; b_cfg_addr = '0; b_cfg_wdata = '0; b_tready = 0;
    aresetn  = 1'b1;
    #2 aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // Reset state.
    check("rst_a_tvalid",  32'(a_tvalid),    32'd0);
    check("rst_a_tlast",   32'(a_tlast),     32'd0);
    check("rst_a_tdata",   32'(a_tdata),     32'd0);
    check("rst_a_ram_we",  32'(a_ram_we),    32'd0);
    check("rst_a_ram_addr",32'(a_ram_addr),  32'd2);
    check("rst_a_wdata",   32'(a_ram_wdata), 32'd0);
    check("rst_a_cfg_ack", 32'(a_cfg_ack),   32'd0);
    check("rst_b_tvalid",  32'(b_tvalid),    32'd0);
    check("rst_b_ram_addr",32'(b_ram_addr),  32'd0);

    aresetn = 1'b1;
    next_cycle();

    // Steady stream with a config write to address 4 in cycle 8.
    vecs[0]  = mk(10'd2, 0, 0, 18'h000, 0);
    vecs[1]  = mk(10'd3, 0, 0, 18'h000, 0);
    vecs[2]  = mk(10'd4, 0, 0, 18'h000, 0);
    vecs[3]  = mk(10'd5, 0, 1, 18'h102, 0);
    vecs[4]  = mk(10'd2, 0, 1, 18'h103, 0);
    vecs[5]  = mk(10'd3, 0, 1, 18'h104, 0);
    vecs[6]  = mk(10'd4, 0, 1, 18'h105, 1);
    vecs[7]  = mk(10'd5, 0, 1, 18'h102, 0);
    vecs[8]  = mk(10'd4, 1, 1, 18'h103, 0);
    vecs[9]  = mk(10'd2, 0, 1, 18'h104, 0);
    vecs[10] = mk(10'd3, 0, 1, 18'h105, 1);
    vecs[11] = mk(10'd4, 0, 0, 18'h000, 0);
    vecs[12] = mk(10'd5, 0, 1, 18'h102, 0);
    vecs[13] = mk(10'd2, 0, 1, 18'h103, 0);
    vecs[14] = mk(10'd3, 0, 1, 18'h3AA, 0);
    vecs[15] = mk(10'd4, 0, 1, 18'h105, 1);

    for (int k = 0; k < 16; k++) begin
      a_enable    = vecs[k].en;
      a_cfg_we    = vecs[k].we;
      a_cfg_addr  = vecs[k].waddr;
      a_cfg_wdata = vecs[k].wdata;
      a_tready    = vecs[k].rdy;
      @(negedge aclk);
      check($sformatf("v%0d_ram_we", k),   32'(a_ram_we),   32'(vecs[k].x_we));
      check($sformatf("v%0d_ram_addr", k), 32'(a_ram_addr), 32'(vecs[k].x_addr));
      check($sformatf("v%0d_cfg_ack", k),  32'(a_cfg_ack),  32'(vecs[k].x_ack));
      check($sformatf("v%0d_tvalid", k),   32'(a_tvalid),   32'(vecs[k].x_valid));
      if (vecs[k].x_valid) begin
        check($sformatf("v%0d_tdata", k), 32'(a_tdata), 32'(vecs[k].x_data));
        check($sformatf("v%0d_tlast", k), 32'(a_tlast), 32'(vecs[k].x_last));
      end
      if (vecs[k].we) begin
        check($sformatf("v%0d_ram_wdata", k), 32'(a_ram_wdata), 32'(vecs[k].wdata));
      end
      next_cycle();
    end
    a_cfg_we  = 1'b0;
    cfg4_done = 1'b1;

    // Fill the FIFO under backpressure, then reset asynchronously mid-cycle.
    a_enable = 1'b1;
    a_tready = 1'b0;
    @(negedge aclk);
    check("stall_head_valid", 32'(a_tvalid), 32'd1);
    check("stall_head_data",  32'(a_tdata),  32'h102);
    repeat (5) @(posedge aclk);
    #3 aresetn = 1'b0;
    #1;
    check("async_rst_tvalid",   32'(a_tvalid),   32'd0);
    check("async_rst_ram_addr", 32'(a_ram_addr), 32'd2);
    check("async_rst_tdata",    32'(a_tdata),    32'd0);
    check("async_rst_tlast",    32'(a_tlast),    32'd0);
    a_enable = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_no_tvalid", 32'(a_tvalid), 32'd0);
    next_cycle();

    // Restart with tready low for cycles 5..24.
    fill_a(60);
    sb_a_on = 1'b1;
    for (int k = 0; k < 45; k++) begin
      a_enable = 1'b1;
      a_tready = !(k >= 5 && k < 25);
      @(negedge aclk);
      if (k == 3) begin
        check("restart_first_valid", 32'(a_tvalid), 32'd1);
        check("restart_first_data",  32'(a_tdata),  32'h102);
      end
      if (k == 15) begin
        check("bp_issue_held_addr", 32'(a_ram_addr), 32'd4);
        check("bp_head_data",       32'(a_tdata),    32'h3AA);
      end
      next_cycle();
    end
    do_reset();

    // enable low for cycles 10..15 with tready held high.
    fill_a(60);
    win = 0;
    for (int k = 0; k < 40; k++) begin
      a_enable = !(k >= 10 && k <= 15);
      a_tready = 1'b1;
      @(negedge aclk);
      if (k >= 10 && k <= 15) begin
        check($sformatf("en_low_addr_c%0d", k), 32'(a_ram_addr), 32'd4);
        if (a_tvalid) win++;
      end
      if (k >= 13 && k <= 15) begin
        check($sformatf("en_low_drained_c%0d", k), 32'(a_tvalid), 32'd0);
      end
      next_cycle();
    end
    check("en_low_words_after_drop", 32'(win), 32'd3);
    do_reset();
    sb_a_on = 1'b0;

    // Instance B: 200 words under random tready.
    fill_b(240);
    sb_b_on = 1'b1;
    for (int c = 0; c < 3000 && b_words < 200; c++) begin
      b_enable = 1'b1;
      b_tready = 1'($urandom_range(0, 1));
      next_cycle();
    end
    b_tready = 1'b0;
    b_enable = 1'b0;
    check("b_words_done", 32'(b_words), 32'd200);
    check("b_tlast_count", 32'(b_lasts), 32'd12);

    repeat (3) next_cycle();
    check("no_fifo_overflow", 32'(ovf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
